// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: one-step registered multiply, 32-step restoring
// divide with sign fix-up; busy stalls EX, done pulses result and rd tag to writeback.
module muldiv_seq #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            i_mul,
    input  logic            i_mulh,
    input  logic            i_mulhsu,
    input  logic            i_mulhu,
    input  logic            i_div,
    input  logic            i_divu,
    input  logic            i_rem,
    input  logic            i_remu,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {IDLE, RES, DIV, FIX} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t             r_state;
    op_t                r_op;
    logic [XLEN-1:0]    r_a, r_b;
    logic [XLEN-1:0]    r_quo, r_rem, r_dvs;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_rd_pend;
    logic               r_neg;

    logic [7:0]         w_ops;
    logic               w_onehot;
    op_t                w_op;
    logic               w_in_div, w_in_signed, w_b_zero, w_ovf;
    logic [XLEN-1:0]    w_abs_a, w_abs_b;

    assign w_ops    = {i_remu, i_rem, i_divu, i_div, i_mulhu, i_mulhsu, i_mulh, i_mul};
    assign w_onehot = (w_ops != 8'd0) && ((w_ops & (w_ops - 8'd1)) == 8'd0);

    always_comb begin
        w_op = OP_MUL;
        if (w_ops[1])      w_op = OP_MULH;
        else if (w_ops[2]) w_op = OP_MULHSU;
        else if (w_ops[3]) w_op = OP_MULHU;
        else if (w_ops[4]) w_op = OP_DIV;
        else if (w_ops[5]) w_op = OP_DIVU;
        else if (w_ops[6]) w_op = OP_REM;
        else if (w_ops[7]) w_op = OP_REMU;
    end

    assign w_in_div    = (w_ops[7:4] != 4'd0);
    assign w_in_signed = i_div | i_rem;
    assign w_b_zero    = (rs2_val == '0);
    assign w_ovf       = w_in_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    assign w_abs_a     = (w_in_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    assign w_abs_b     = (w_in_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

    // 33-bit operands extended to 66 bits so an unsigned multiply yields the signed product
    logic [XLEN:0]      w_ma, w_mb;
    logic [2*XLEN+1:0]  w_prod;

    assign w_ma   = {((r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_MULHSU)) & r_a[XLEN-1], r_a};
    assign w_mb   = {((r_op == OP_MUL) || (r_op == OP_MULH)) & r_b[XLEN-1], r_b};
    assign w_prod = {{(XLEN+1){w_ma[XLEN]}}, w_ma} * {{(XLEN+1){w_mb[XLEN]}}, w_mb};

    // Partial remainder stays below the divisor, so it fits in XLEN bits between steps
    logic [XLEN:0]      w_shift;
    logic [XLEN+1:0]    w_diff;
    logic               w_ge;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_diff[XLEN+1];

    logic [XLEN-1:0]    w_res, w_fix;

    always_comb begin
        w_res = w_prod[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:           w_res = w_prod[XLEN-1:0];
            OP_DIV, OP_DIVU:  w_res = (r_b == '0) ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            OP_REM, OP_REMU:  w_res = (r_b == '0) ? r_a : '0;
            default:          w_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        if ((r_op == OP_DIV) || (r_op == OP_DIVU))
            w_fix = r_neg ? -r_quo : r_quo;
        else
            w_fix = r_neg ? -r_rem : r_rem;
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_rd_pend <= '0;
            r_neg     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        if (!w_onehot) begin
                            illegal <= 1'b1;
                        end else begin
                            r_op      <= w_op;
                            r_a       <= rs1_val;
                            r_b       <= rs2_val;
                            r_rd_pend <= rd_in;
                            r_neg     <= i_div ? (rs1_val[XLEN-1] ^ rs2_val[XLEN-1])
                                               : (i_rem & rs1_val[XLEN-1]);
                            r_quo     <= w_abs_a;
                            r_rem     <= '0;
                            r_dvs     <= w_abs_b;
                            r_cnt     <= '0;
                            r_state   <= (w_in_div && !w_b_zero && !w_ovf) ? DIV : RES;
                        end
                    end
                end
                RES: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        result  <= w_res;
                        rd_out  <= r_rd_pend;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DIV_ITERS-1))
                            r_state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        result  <= w_fix;
                        rd_out  <= r_rd_pend;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against a plain-arithmetic RV32M model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic        i_mul, i_mulh, i_mulhsu, i_mulhu, i_div, i_divu, i_rem, i_remu;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        busy, done, illegal;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errs   = 0;
    int checks = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    muldiv_seq #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .i_mul(i_mul), .i_mulh(i_mulh), .i_mulhsu(i_mulhsu), .i_mulhu(i_mulhu),
        .i_div(i_div), .i_divu(i_divu), .i_rem(i_rem), .i_remu(i_remu),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // op index: 0 mul 1 mulh 2 mulhsu 3 mulhu 4 div 5 divu 6 rem 7 remu
    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = 32'h0;
        case (op)
            0: begin p = sa * sb; model = p[31:0];  end
            1: begin p = sa * sb; model = p[63:32]; end
            2: begin p = sa * ub; model = p[63:32]; end
            3: begin p = ua * ub; model = p[63:32]; end
            4: model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            6: model = (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op < 4 || b == 0) return 2;
        if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic clr_in();
        start = 1'b0;
        {i_remu, i_rem, i_divu, i_div, i_mulhu, i_mulhsu, i_mulh, i_mul} = 8'h00;
    endtask

    task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        {i_remu, i_rem, i_divu, i_div, i_mulhu, i_mulhsu, i_mulh, i_mul} = 8'(1 << op);
        start   = 1'b1;
    endtask

    // Called at the negedge of the start cycle; returns at the negedge of the done cycle.
    task automatic wait_done(input int exp_lat, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                             input string tag, input int inject_at);
        int k;
        bit got, bad_busy, saw_ill;
        got = 0; bad_busy = 0; saw_ill = 0; k = 0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                clr_in();
                rs1_val = $urandom;
                rs2_val = $urandom;
                rd_in   = 5'($urandom);
            end
            if (k == inject_at) begin
                start = 1'b1;
                i_mul = 1'b1;
            end else if (inject_at > 0 && k == inject_at + 1) begin
                clr_in();
            end
            if (illegal) saw_ill = 1;
            if (done) got = 1;
            else if (!busy) bad_busy = 1;
        end
        chk({tag, " latency"}, 64'(got ? k : 0), 64'(exp_lat));
        chk({tag, " result"}, 64'(result), 64'(exp_res));
        chk({tag, " rd_out"}, 64'(rd_out), 64'(exp_rd));
        chk({tag, " busy/illegal"}, {61'd0, bad_busy, busy, saw_ill}, 64'd0);
        last_res = exp_res;
        last_rd  = exp_rd;
    endtask

    task automatic run_dir(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input int lat, input string tag);
        start_op(op, a, b, rd);
        wait_done(lat, exp, rd, tag, 0);
    endtask

    task automatic run_rand(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start_op(op, a, b, rd);
        wait_done(lat_of(op, a, b), model(op, a, b), rd, $sformatf("rand op%0d %h,%h", op, a, b), 0);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; flush = 1'b0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        clr_in();
        repeat (3) @(negedge clk);
        chk("reset outputs", {27'd0, busy, done, illegal, rd_out, result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_dir(0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2,  "mul");
        run_dir(3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2,  "mulhu");
        run_dir(1, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 2,  "mulh");
        run_dir(2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 2,  "mulhsu");
        run_dir(4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34, "div neg");
        run_dir(6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34, "rem neg");
        run_dir(5, 32'd100,        32'd7,         5'd11, 32'd14,        34, "divu");
        run_dir(7, 32'd100,        32'd7,         5'd12, 32'd2,         34, "remu");
        run_dir(4, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 2,  "div by 0");
        run_dir(6, 32'd5,          32'd0,         5'd14, 32'd5,         2,  "rem by 0");
        run_dir(4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2,  "div ovf");
        run_dir(6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         2,  "rem ovf");
        // back-to-back: next start issued in the done cycle of the previous op
        run_dir(0, 32'd3,          32'd4,         5'd17, 32'd12,        2,  "b2b mul");

        // start while busy must be ignored
        start_op(4, 32'd1000, 32'd7, 5'd3);
        wait_done(34, 32'd142, 5'd3, "start while busy", 3);

        // flush in cycle N+10 of a divide
        start_op(4, 32'd1000, 32'd3, 5'd11);
        saw_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) clr_in();
            if (done) saw_done = 1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) saw_done = 1;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush no done", 64'(saw_done), 64'd0);
        chk("flush result kept", {27'd0, rd_out, result}, {27'd0, last_rd, last_res});
        run_dir(0, 32'd6, 32'd7, 5'd12, 32'd42, 2, "post-flush mul");

        // illegal: two flags, then zero flags
        @(negedge clk);
        start = 1'b1; i_mul = 1'b1; i_div = 1'b1;
        @(negedge clk);
        clr_in();
        chk("illegal two-hot", {62'd0, illegal, busy}, 64'b10);
        @(negedge clk);
        chk("illegal one pulse", 64'(illegal), 64'd0);
        start = 1'b1;
        @(negedge clk);
        clr_in();
        chk("illegal zero-hot", {62'd0, illegal, busy}, 64'b10);

        // flush and start together in IDLE drop the start
        @(negedge clk);
        start_op(0, 32'd9, 32'd9, 5'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clr_in();
        chk("flush+start busy", {62'd0, busy, illegal}, 64'd0);
        @(negedge clk);
        chk("flush+start no done", {27'd0, done, rd_out, result}, {28'd0, last_rd, last_res});

        // reset in cycle N+5 of a divide
        start_op(4, 32'd12345, 32'd17, 5'd21);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) clr_in();
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-op reset", {27'd0, busy, done, illegal, rd_out, result}, 64'd0);

        for (int n = 0; n < 40; n++) begin
            int op, sel;
            logic [31:0] a, b;
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = $urandom_range(1, 16);
            else if (sel == 3) b = -32'($urandom_range(1, 16));
            run_rand(op, a, b, 5'($urandom));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
